reg_dump: RTL and testbench



---
 rtl/reg_dump_pkg.sv | 22 ++
 rtl/reg_dump.sv | 181 ++++++++++++++++++
 tb/tb_reg_dump.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and constants for the register-file dump engine.
// The optional checksum word is enabled by defining REG_DUMP_CHECKSUM_EN.
package reg_dump_pkg;

  // Default geometry of the 16x16 register file being dumped.
  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_REGBITS = 4;

  // The checksum word is tagged with an all-ones address. Consumers
  // truncate this to their own address width.
  localparam logic [31:0] CHECKSUM_ADDR_ALL = '1;

  // Dump sequencer states. SUM is reachable only in checksum builds.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    SUM  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: debug readback engine that walks FIRST_REG..LAST_REG through one
// register-file read port and streams each captured value on valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the dump.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int REGBITS   = DEFAULT_REGBITS,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = (1 << REGBITS) - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [REGBITS-1:0] rf_ra,
  input  logic [WIDTH-1:0]   rf_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [REGBITS-1:0] out_addr,
  output logic               out_last
);

  localparam logic [REGBITS-1:0] FIRST_ADDR = REGBITS'(FIRST_REG);
  localparam logic [REGBITS-1:0] LAST_ADDR  = REGBITS'(LAST_REG);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [REGBITS-1:0] SUM_ADDR   = REGBITS'(CHECKSUM_ADDR_ALL);
`endif

  state_t             r_state;
  state_t             w_nextState;
  logic [REGBITS-1:0] r_addr;
  logic [WIDTH-1:0]   r_outData;
  logic [REGBITS-1:0] r_outAddr;
  logic               r_outValid;
  logic               r_outLast;
  logic               w_handshake;
  logic               w_atLast;
  logic               w_startAccept;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0]   r_sum;
`endif

  assign w_handshake   = r_outValid && out_ready;
  assign w_atLast      = (r_addr == LAST_ADDR);
  assign w_startAccept = (r_state == IDLE) && start;

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_addr  = r_outAddr;
  assign out_last  = r_outLast;

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one READ cycle per word, then wait in SEND for the handshake.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = READ;
        end
      end
      READ: begin
        w_nextState = SEND;
      end
      SEND: begin
        if (w_handshake) begin
          if (w_atLast) begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_nextState = SUM;
`else
            w_nextState = DONE;
`endif
          end else begin
            w_nextState = READ;
          end
        end
      end
      SUM: begin
        if (w_handshake) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Status outputs and read address decoded from the current state.
  always_comb begin
    busy  = (r_state != IDLE);
    done  = (r_state == DONE);
    rf_ra = (r_state == IDLE) ? FIRST_ADDR : r_addr;
  end

  // Address counter: compared against LAST before incrementing so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= FIRST_ADDR;
    end else if (w_startAccept) begin
      r_addr <= FIRST_ADDR;
    end else if ((r_state == SEND) && w_handshake && !w_atLast) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Output word register: snapshot taken at the READ edge, held until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outData  <= '0;
      r_outAddr  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else begin
      case (r_state)
        READ: begin
          r_outData  <= rf_rd;
          r_outAddr  <= r_addr;
          r_outValid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          r_outLast  <= 1'b0;
`else
          r_outLast  <= w_atLast;
`endif
        end
        SEND: begin
          if (w_handshake) begin
`ifdef REG_DUMP_CHECKSUM_EN
            if (w_atLast) begin
              r_outData  <= r_sum ^ r_outData;
              r_outAddr  <= SUM_ADDR;
              r_outLast  <= 1'b1;
              r_outValid <= 1'b1;
            end else begin
              r_outValid <= 1'b0;
            end
`else
            r_outValid <= 1'b0;
`endif
          end
        end
        SUM: begin
          if (w_handshake) begin
            r_outValid <= 1'b0;
          end
        end
        default: begin
          r_outValid <= r_outValid;
        end
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Checksum accumulator: cleared on an accepted start, folds in every accepted register word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_startAccept) begin
      r_sum <= '0;
    end else if ((r_state == SEND) && w_handshake) begin
      r_sum <= r_sum ^ r_outData;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: scoreboard bench for reg_dump. Expected words are pushed when
// a dump is started; per-instance monitors compare whatever the DUT presents.
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  addr;
    logic        last;
  } word_t;

  logic        clk;
  logic        reset;
  logic [15:0] regs [16];

  logic        startA, busyA, doneA, validA, readyA, lastA;
  logic [3:0]  raA, addrA;
  logic [15:0] rdA, dataA;

  logic        startB, busyB, doneB, validB, readyB, lastB;
  logic [3:0]  raB, addrB;
  logic [15:0] rdB, dataB;

  word_t expA[$];
  word_t expB[$];

  int assertCount = 0;
  int failCount   = 0;
  int doneCntA    = 0;
  int doneCntB    = 0;
  int readyMode   = 0;
  int stallAddr   = 3;
  int stallCnt    = 0;

  assign rdA = (raA == 4'd0) ? 16'h0000 : regs[raA];
  assign rdB = (raB == 4'd0) ? 16'h0000 : regs[raB];

  reg_dump dutA (
    .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .rf_ra(raA), .rf_rd(rdA), .out_valid(validA), .out_ready(readyA),
    .out_data(dataA), .out_addr(addrA), .out_last(lastA)
  );

  reg_dump #(.FIRST_REG(7), .LAST_REG(7)) dutB (
    .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .rf_ra(raB), .rf_rd(rdB), .out_valid(validB), .out_ready(readyB),
    .out_data(dataB), .out_addr(addrB), .out_last(lastB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input word_t act, input word_t exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got data=%h addr=%h last=%b, expected data=%h addr=%h last=%b",
               name, act.data, act.addr, act.last, exp.data, exp.addr, exp.last);
    end
  endtask

  // Monitor for instance A: every presented word must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (doneA) doneCntA++;
      if (validA) begin
        if (expA.size() == 0) begin
          checkWord("A unexpected word", {dataA, addrA, lastA}, '0);
        end else begin
          checkWord("A word", {dataA, addrA, lastA}, expA[0]);
          if (readyA) void'(expA.pop_front());
        end
      end
    end
  end

  // Monitor for instance B (single-register dump).
  always @(negedge clk) begin
    if (!reset) begin
      if (doneB) doneCntB++;
      if (validB) begin
        if (expB.size() == 0) begin
          checkWord("B unexpected word", {dataB, addrB, lastB}, '0);
        end else begin
          checkWord("B word", {dataB, addrB, lastB}, expB[0]);
          if (readyB) void'(expB.pop_front());
        end
      end
    end
  end

  // Ready driver for A: always ready, random, or a 5-cycle stall on stallAddr.
  initial begin
    readyA = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: readyA = 1'b1;
        1: readyA = 1'($urandom_range(0, 1));
        default: begin
          if (validA && addrA == 4'(stallAddr) && stallCnt < 5) begin
            if (readyMode == 3 && stallCnt == 0) regs[4] = 16'h0000;
            readyA = 1'b0;
            stallCnt++;
          end else begin
            readyA = 1'b1;
          end
        end
      endcase
    end
  end

  // Starts a dump and queues the words it must produce from the current register contents.
  task automatic applyStimulus(input bit useB);
    int first = useB ? 7 : 0;
    int last  = useB ? 7 : 15;
    logic [15:0] x = 16'h0000;
    word_t w;
    @(posedge clk);
    #1;
    if (useB) startB = 1'b1; else startA = 1'b1;
    for (int a = first; a <= last; a++) begin
      w.data = (a == 0) ? 16'h0000 : regs[a];
      w.addr = 4'(a);
      w.last = (a == last) && !CSUM;
      x = x ^ w.data;
      if (useB) expB.push_back(w); else expA.push_back(w);
    end
    if (CSUM) begin
      w.data = x;
      w.addr = 4'hF;
      w.last = 1'b1;
      if (useB) expB.push_back(w); else expA.push_back(w);
    end
    @(posedge clk);
    #1;
    startA = 1'b0;
    startB = 1'b0;
    @(negedge clk);
    checkOutput("busy one cycle after start", 32'(useB ? busyB : busyA), 32'd1);
    checkOutput("valid not yet", 32'(useB ? validB : validA), 32'd0);
    @(negedge clk);
    checkOutput("first valid latency", 32'(useB ? validB : validA), 32'd1);
  endtask

  // Waits for done with a cycle budget, checking busy throughout and one done pulse.
  task automatic waitDone(input bit useB, input int injectAddr);
    int  doneStart = useB ? doneCntB : doneCntA;
    bit  seen      = 1'b0;
    bit  injected  = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      checkOutput("busy during dump", 32'(useB ? busyB : busyA), 32'd1);
      if (useB ? doneB : doneA) seen = 1'b1;
      if (!useB && injectAddr >= 0 && !injected && validA && addrA == 4'(injectAddr)) begin
        startA   = 1'b1;
        injected = 1'b1;
      end else begin
        startA = 1'b0;
      end
    end
    startA = 1'b0;
    if (!seen) checkOutput("done timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("busy drops after done", 32'(useB ? busyB : busyA), 32'd0);
    checkOutput("done single pulse", 32'(useB ? doneB : doneA), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("done count", 32'((useB ? doneCntB : doneCntA) - doneStart), 32'd1);
    checkOutput("queue drained", 32'(useB ? expB.size() : expA.size()), 32'd0);
  endtask

  task automatic preload();
    regs[0] = 16'h0000;
    for (int i = 1; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    bit found;
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    readyB = 1'b1;
    preload();
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset done", 32'(doneA), 32'd0);
    checkOutput("reset valid", 32'(validA), 32'd0);
    checkOutput("reset last", 32'(lastA), 32'd0);
    checkOutput("reset data", 32'(dataA), 32'd0);
    checkOutput("reset addr", 32'(addrA), 32'd0);
    checkOutput("reset ra", 32'(raA), 32'd0);
    checkOutput("reset B valid", 32'(validB), 32'd0);
    reset = 1'b0;

    $display("[TB] full dump, ready tied high, start pulsed while busy at addr 5");
    readyMode = 0;
    applyStimulus(1'b0);
    waitDone(1'b0, 5);

    $display("[TB] backpressure on addr 3");
    readyMode = 2; stallAddr = 3; stallCnt = 0;
    applyStimulus(1'b0);
    waitDone(1'b0, -1);
    checkOutput("stall cycles applied", 32'(stallCnt), 32'd5);

    $display("[TB] register write during SEND of addr 4");
    readyMode = 3; stallAddr = 4; stallCnt = 0;
    applyStimulus(1'b0);
    waitDone(1'b0, -1);
    regs[4] = 16'h1004;

    $display("[TB] single-register dump FIRST=LAST=7");
    regs[7] = 16'hBEEF;
    applyStimulus(1'b1);
    waitDone(1'b1, -1);
    regs[7] = 16'h1007;

    $display("[TB] reset mid-dump at addr 9");
    readyMode = 0;
    applyStimulus(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk);
      #2;
      if (validA && addrA == 4'd9) found = 1'b1;
    end
    if (!found) checkOutput("addr 9 timeout", 32'd0, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort valid", 32'(validA), 32'd0);
    checkOutput("abort busy", 32'(busyA), 32'd0);
    checkOutput("abort ra", 32'(raA), 32'd0);
    expA.delete();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0);
    waitDone(1'b0, -1);

    $display("[TB] randomized dumps");
    readyMode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 1; i < 16; i++) regs[i] = 16'($urandom);
      applyStimulus(1'b0);
      waitDone(1'b0, -1);
    end
    for (int i = 1; i < 16; i++) regs[i] = 16'($urandom);
    applyStimulus(1'b1);
    waitDone(1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
